// File: rtl/shift_seq_engine.sv
// shift_seq_engine: multi-cycle shift/rotate engine, one bit position per clock,
// bit-exact with the combinational shift_dut for the same op and amount.
module shift_seq_engine #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [2:0]       in_op,
   input  logic [AMT_W-1:0] in_amt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_err,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state, state_n;
   logic [WIDTH-1:0] data_q, step;
   logic [2:0]       op_q;
   logic [AMT_W-1:0] cnt_q;
   logic             err_q, illegal, accept;
   always_comb begin
      illegal   = in_op > 3'd4;
      in_ready  = state == IDLE;
      out_valid = state == DONE;
      busy      = state != IDLE;
      accept    = in_ready && in_valid;
      out_data  = data_q;
      out_err   = err_q;
      step = op_q == 3'd0 ? {data_q[WIDTH-2:0], 1'b0} :
             op_q == 3'd1 ? {1'b0, data_q[WIDTH-1:1]} :
             op_q == 3'd2 ? {data_q[WIDTH-1], data_q[WIDTH-1:1]} :
             op_q == 3'd3 ? {data_q[WIDTH-2:0], data_q[WIDTH-1]} :
                            {data_q[0], data_q[WIDTH-1:1]};
   end
   always_comb begin
      state_n = state;
      if (accept) state_n = (in_amt == '0 || illegal) ? DONE : SHIFT;
      else if (state == SHIFT && cnt_q == AMT_W'(1)) state_n = DONE;
      else if (state == DONE && out_ready) state_n = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         data_q <= '0;
         op_q   <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) begin
            data_q <= in_data;
            op_q   <= in_op;
            cnt_q  <= in_amt;
            err_q  <= illegal;
         end else if (state == SHIFT) begin
            data_q <= step;
            cnt_q  <= cnt_q - AMT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_shift_seq_engine.sv
// tb_shift_seq_engine: directed scoreboard bench; stimulus queues expected
// results, a negedge monitor checks latency, stability and result values.
module tb_shift_seq_engine;
   logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
   logic [7:0] in_data = 0;
   logic [2:0] in_op = 0;
   logic [2:0] in_amt = 0;
   logic in_ready, out_valid, out_err, busy;
   logic [7:0] out_data;
   int tests = 0, fails = 0, cyc = 0;
   logic [7:0] exp_d[$];
   logic exp_e[$];
   int exp_l[$], acc_q[$];
   logic held = 0, was_hs = 0;
   logic [7:0] hold_d;

   shift_seq_engine dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_op(in_op), .in_amt(in_amt), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_err(out_err), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] op, input int n);
      logic signed [7:0] s;
      s = d;
      case (op)
         3'd0: return d << n;
         3'd1: return d >> n;
         3'd2: return s >>> n;
         3'd3: return (d << n) | (d >> (8 - n));
         3'd4: return (d >> n) | (d << (8 - n));
         default: return d;
      endcase
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         exp_d.delete(); exp_e.delete(); exp_l.delete(); acc_q.delete();
         held = 0; was_hs = 0;
      end else begin
         if (in_valid && in_ready) acc_q.push_back(cyc + 1);
         if (was_hs) chk("idle_after_handshake", in_ready, 1);
         if (out_valid) begin
            chk("in_ready_low_in_done", in_ready, 0);
            chk("busy_in_done", busy, 1);
            if (exp_d.size() == 0 || acc_q.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               if (!held) chk("latency", cyc - acc_q[0], exp_l[0]);
               else chk("held_stable", out_data, hold_d);
               if (out_ready) begin
                  chk("result_data", out_data, exp_d[0]);
                  chk("result_err", out_err, exp_e[0]);
                  void'(exp_d.pop_front()); void'(exp_e.pop_front());
                  void'(exp_l.pop_front()); void'(acc_q.pop_front());
               end
            end
            hold_d = out_data;
         end
         held = out_valid && !out_ready;
         was_hs = out_valid && out_ready;
      end
   end

   task automatic req(input logic [7:0] d, input logic [2:0] op, input logic [2:0] amt,
                      input bit keep, output int acc);
      int n;
      n = (op > 4 || amt == 0) ? 0 : amt;
      exp_d.push_back(op > 4 ? d : model(d, op, amt));
      exp_e.push_back(op > 4);
      exp_l.push_back(n);
      in_data = d; in_op = op; in_amt = amt; in_valid = 1;
      acc = -1;
      for (int i = 0; i < 40 && acc < 0; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk); #1;
            acc = cyc;
         end
      end
      if (acc < 0) chk("accept_timeout", 0, 1);
      if (!keep) in_valid = 0;
   endtask

   task automatic drain();
      int i;
      for (i = 0; i < 60 && exp_d.size() != 0; i++) @(posedge clk);
      if (exp_d.size() != 0) chk("drain_timeout", exp_d.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      int a, pa, pn;
      logic [7:0] vd[8] = '{8'hA5, 8'h3C, 8'h81, 8'hF0, 8'h5A, 8'h01, 8'hC3, 8'h7E};
      logic [2:0] vo[8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd2, 3'd3};
      logic [2:0] va[8] = '{3'd3, 3'd0, 3'd6, 3'd7, 3'd1, 3'd4, 3'd2, 3'd5};
      repeat (2) @(posedge clk);
      #1 rst = 0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_err", out_err, 0);
      chk("rst_busy", busy, 0);
      for (int op = 0; op < 5; op++) begin
         req(8'b11101011, 3'(op), 3'd1, 0, a);
         drain();
      end
      req(8'b11101011, 3'd3, 3'd3, 0, a); drain();
      req(8'b11101011, 3'd2, 3'd7, 0, a); drain();
      req(8'b11101011, 3'd0, 3'd7, 0, a); drain();
      req(8'b11101011, 3'd1, 3'd7, 0, a); drain();
      req(8'b10010110, 3'd4, 3'd0, 0, a); drain();
      req(8'b10010110, 3'd6, 3'd5, 0, a); drain();
      // hold the result while a competing request is offered
      out_ready = 0;
      req(8'b11111111, 3'd4, 3'd2, 0, a);
      in_valid = 1; in_data = 8'h12; in_op = 0; in_amt = 1;
      repeat (10) @(posedge clk);
      #1 chk("bp_valid_held", out_valid, 1);
      chk("bp_data_held", out_data, 8'hFF);
      in_valid = 0;
      out_ready = 1;
      drain();
      req(8'h5A, 3'd0, 3'd7, 0, a);
      repeat (3) @(posedge clk);
      #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_data", out_data, 0);
      req(8'h96, 3'd3, 3'd4, 0, a); drain();
      pa = -1; pn = 0;
      for (int i = 0; i < 8; i++) begin
         req(vd[i], vo[i], va[i], 1, a);
         if (pa >= 0) chk("b2b_spacing", a - pa, pn + 2);
         pa = a;
         pn = (vo[i] > 4 || va[i] == 0) ? 0 : int'(va[i]);
      end
      in_valid = 0;
      drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
